// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle ramp controller in front of a PWM generator: buttons and host writes
// share one target, and the applied duty walks toward it only on PWM period boundaries.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W       = 4,
  parameter int DUTY_MAX     = 10,
  parameter int DEFAULT_DUTY = 5,
  parameter int RAMP_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              period_start,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              set_valid,
  input  logic [DUTY_W-1:0] set_duty,
  output logic              set_ready,
  output logic [DUTY_W-1:0] duty,
  output logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              at_target,
  output logic              clamp_err
);

  localparam int CNT_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [DUTY_W-1:0] MAX  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DFLT = DUTY_W'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(RAMP_PERIODS - 1);

  typedef enum logic [2:0] {
    S_OFF  = 3'b001,
    S_IDLE = 3'b010,
    S_RAMP = 3'b100
  } state_t;

  state_t            state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt, target_nxt, step;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              set_accept, clamp_nxt;
  logic              busy_nxt, at_target_nxt, set_ready_nxt;

  // set_ready is a registered copy of (state != RAMP), so gating on it is exact
  assign set_accept = set_valid && set_ready;
  assign step       = (duty < target) ? duty + 1'b1 : duty - 1'b1;

  // Target register: host write wins over buttons; saturate before +/-1.
  always_comb begin
    target_nxt = target;
    clamp_nxt  = 1'b0;
    if (set_accept) begin
      clamp_nxt  = (set_duty > MAX);
      target_nxt = (set_duty > MAX) ? MAX : set_duty;
    end else if (inc_pulse && !dec_pulse && (target < MAX)) begin
      target_nxt = target + 1'b1;
    end else if (dec_pulse && !inc_pulse && (target != '0)) begin
      target_nxt = target - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OFF;
      busy      <= 1'b0;
      at_target <= 1'b0;
      set_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      at_target <= at_target_nxt;
      set_ready <= set_ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    cnt_nxt   = cnt;
    case (state)
      S_OFF: begin
        duty_nxt = '0;
        if (enable) begin
          state_nxt = (target != '0) ? S_RAMP : S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_IDLE, S_RAMP: begin
        // A pending shutdown freezes the duty until the period boundary.
        if (!enable) begin
          if (period_start) begin
            duty_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = S_OFF;
          end
        end else if (state == S_IDLE) begin
          if (target != duty) begin
            state_nxt = S_RAMP;
            cnt_nxt   = '0;
          end
        end else if (target == duty) begin
          state_nxt = S_IDLE;
        end else if (period_start) begin
          if (cnt == LAST) begin
            duty_nxt = step;
            cnt_nxt  = '0;
            if (step == target) state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_OFF;
        duty_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    busy_nxt      = (state_nxt == S_RAMP);
    at_target_nxt = (state_nxt == S_IDLE);
    set_ready_nxt = (state_nxt != S_RAMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty      <= '0;
      target    <= DFLT;
      cnt       <= '0;
      clamp_err <= 1'b0;
    end else begin
      duty      <= duty_nxt;
      target    <= target_nxt;
      cnt       <= cnt_nxt;
      clamp_err <= clamp_nxt;
    end
  end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
Duty-cycle controller that sits in front of the PWM generator and sets its duty input. It takes debounced inc/dec button pulses and host set-point writes. Button pulses share one target register with host writes, and host writes win on conflict. It ramps the applied duty toward the target one step at a time, with every change aligned to a PWM period boundary so the output never glitches.

Parameters:
DUTY_W, 4, width of duty/target values
DUTY_MAX, 10, maximum legal duty (10 = 100% for a 10-step PWM period)
DEFAULT_DUTY, 5, target value after reset (50%)
RAMP_PERIODS, 2, PWM periods per one-step duty change (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = run PWM; 0 = soft shutdown to duty 0
period_start  in  1  one-cycle pulse from PWM counter wrap (count 9->0)
inc_pulse  in  1  debounced single-cycle "increase duty" request
dec_pulse  in  1  debounced single-cycle "decrease duty" request
set_valid  in  1  host set-point request
set_duty  in  DUTY_W  host requested target
set_ready  out  1  controller can accept a host set-point
duty  out  DUTY_W  applied duty to PWM generator
target  out  DUTY_W  current target duty
busy  out  1  ramp in progress
at_target  out  1  duty == target and running
clamp_err  out  1  one-cycle pulse: host set_duty > DUTY_MAX was clamped

Behaviour:
- Reset values (any cycle with rst=1, including mid-ramp):
  - state=OFF, duty=0, target=DEFAULT_DUTY, period_cnt=0.
  - set_ready=1, busy=0, at_target=0, clamp_err=0.
- All outputs are registered.
- FSM states: OFF, IDLE, RAMP.
  - busy = (state==RAMP); at_target = (state==IDLE); set_ready = (state!=RAMP).
- Target update, evaluated every cycle in every state:
  - Host write is accepted when set_valid && set_ready.
    - target <= min(set_duty, DUTY_MAX).
    - If set_duty > DUTY_MAX, clamp_err=1 on the next cycle.
    - Button pulses in the same cycle are discarded.
  - Otherwise, buttons adjust the target:
    - inc_pulse && !dec_pulse: target+1, saturating at DUTY_MAX.
    - dec_pulse && !inc_pulse: target-1, saturating at 0.
    - Both pulses together: no change.
  - During RAMP, set_valid is ignored with no accept. The host holds set_valid until set_ready.
- OFF:
  - duty held at 0.
  - When enable=1: go to RAMP if target!=0, else to IDLE.
- IDLE:
  - If the registered target differs from duty: go to RAMP on the next edge.
  - RAMP entry clears period_cnt.
- RAMP:
  - period_cnt counts period_start pulses only.
  - When period_start=1 and period_cnt==RAMP_PERIODS-1:
    - duty moves one step toward target (+1 if duty<target, -1 if duty>target).
    - period_cnt <= 0.
    - If the new duty equals target, state <= IDLE on the same edge.
  - Direction is re-evaluated at every step, so a target moved past duty mid-ramp reverses the ramp.
  - If target becomes equal to duty with no step due: state <= IDLE on the next edge, duty unchanged.
- Shutdown, from any state:
  - enable=0 in IDLE or RAMP: on the next period_start edge, duty <= 0 and state <= OFF.
  - Until that edge, duty holds its value and no steps occur.
  - target is retained.
  - enable returning to 1 before that period_start cancels the shutdown.
- duty changes only on a clk edge where period_start=1 (latency 0 cycles from the pulse). It never changes mid-period.
- Invariant: 0 <= duty <= DUTY_MAX and 0 <= target <= DUTY_MAX at all times.
- Arithmetic is unsigned DUTY_W bits. Saturation checks must be done before +/-1, so no wrap is possible.

Test Plan:
1. Soft start:
   - Stimulus: rst, then enable=1, period_start every 10 clocks, RAMP_PERIODS=2.
   - Required: duty steps 0,1,2,3,4,5, one step per 2 periods. busy=1 throughout, then at_target=1/busy=0 at duty=5 (after 10 period_starts).
2. Button ramp:
   - Stimulus: in IDLE at 5, apply three inc_pulse.
   - Required: target=8, duty 6,7,8 at 2-period spacing. Then 3 inc_pulse give target 10 (saturates, not 11). Then dec_pulse at target=0 leaves it at 0.
3. Host set:
   - Stimulus A: set_valid with set_duty=13 in IDLE.
     Required: accepted the same cycle, target=10, clamp_err=1 for exactly one cycle.
   - Stimulus B: set_valid during RAMP.
     Required: set_ready=0, target unchanged until IDLE, then accepted.
4. Conflicts:
   - Stimulus: inc_pulse and dec_pulse together; then set_valid (set_duty=2) together with inc_pulse.
   - Required: first leaves target unchanged; second gives target=2.
   - Stimulus: during ramp up 5->9 at duty=7, set target to 3 via dec pulses.
   - Required: duty reverses 7->6->...->3.
5. Shutdown/reset:
   - Stimulus: enable=0 mid-ramp at duty=4.
   - Required: duty stays 4 until the next period_start, then 0, state OFF, target kept. Re-enable ramps 0->target.
   - Stimulus: rst mid-ramp.
   - Required: next cycle duty=0, target=5, busy=0, set_ready=1.
